// File: rtl/warp_dispatcher.sv
// Kernel launch queue and sequencer for simd_core: buffers host submissions,
// drives kernel_in one warp at a time, and tracks per-warp completion.
package warp_dispatcher_pkg;
    localparam int PKG_THREAD_COUNT = 4;
    localparam int TC_W = $clog2(PKG_THREAD_COUNT) + 1;

    typedef struct packed {
        logic [3:0]      warp_id;
        logic [TC_W-1:0] thread_count;
        logic [31:0]     start_pc;
    } kernel_t;
endpackage

module warp_dispatcher
    import warp_dispatcher_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int THREAD_COUNT   = PKG_THREAD_COUNT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           submit_valid,
    input  kernel_t                        submit_kernel,
    output logic                           submit_ready,
    output logic                           submit_reject,
    output kernel_t                        kernel_out,
    input  logic                           is_finished_in,
    input  logic [3:0]                     finished_warp_id,
    output logic [14:0]                    done_mask,
    input  logic [14:0]                    done_clear,
    output logic                           busy,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
    output logic                           finish_err,
    output logic                           timeout
);
    localparam int AW  = $clog2(QUEUE_DEPTH);
    localparam int CW  = AW + 1;
    localparam int WDW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDW-1:0]  WD_LAST = (TIMEOUT_CYCLES == 0) ? '0 : WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [TC_W-1:0] TC_MAX  = TC_W'(THREAD_COUNT);
    localparam kernel_t IDLE_KERNEL = '{warp_id: 4'hF, thread_count: '0, start_pc: '0};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RETIRE} state_t;

    state_t          state, state_nxt;
    kernel_t         mem [QUEUE_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [WDW-1:0]  wdog;
    logic            legal, push, pop;
    logic            fin_match, wd_expire, retire_set;
    logic [14:0]     set_vec;

    assign legal = (submit_kernel.warp_id != 4'hF) &&
                   (submit_kernel.thread_count != '0) &&
                   (submit_kernel.thread_count <= TC_MAX);
    assign submit_ready = (count < CW'(QUEUE_DEPTH));
    assign push         = submit_valid && submit_ready && legal;
    assign busy         = (state != S_IDLE) || (count != '0);
    assign queue_count  = count;

    assign fin_match = (state == S_RUN) && is_finished_in &&
                       (finished_warp_id == kernel_out.warp_id);
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wdog == WD_LAST);
    assign set_vec   = retire_set ? (15'd1 << kernel_out.warp_id) : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        retire_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A matching finish takes priority over a watchdog expiry.
                if (fin_match) begin
                    retire_set = 1'b1;
                    state_nxt  = S_RETIRE;
                end else if (wd_expire) begin
                    state_nxt  = S_RETIRE;
                end
            end
            S_RETIRE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= submit_kernel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            kernel_out    <= IDLE_KERNEL;
            wdog          <= '0;
            done_mask     <= '0;
            submit_reject <= 1'b0;
            finish_err    <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);

            // kernel_out holds through RUN and drops to idle whenever RUN is left.
            if (pop)                     kernel_out <= mem[rd_ptr];
            else if (state_nxt != S_RUN) kernel_out <= IDLE_KERNEL;

            if (state == S_RUN && state_nxt == S_RUN) wdog <= wdog + WDW'(1);
            else                                      wdog <= '0;

            done_mask     <= (done_mask & ~done_clear) | set_vec;
            submit_reject <= submit_valid && submit_ready && !legal;
            finish_err    <= is_finished_in && !fin_match;
            timeout       <= (state == S_RUN) && !fin_match && wd_expire;
        end
    end
endmodule

// File: tb/tb_warp_dispatcher.sv
// Directed vector bench for warp_dispatcher with an 8-cycle watchdog.
module tb_warp_dispatcher;
    import warp_dispatcher_pkg::*;

    logic        clk;
    logic        rst;
    logic        submit_valid;
    kernel_t     submit_kernel;
    logic        submit_ready;
    logic        submit_reject;
    kernel_t     kernel_out;
    logic        is_finished_in;
    logic [3:0]  finished_warp_id;
    logic [14:0] done_mask;
    logic [14:0] done_clear;
    logic        busy;
    logic [2:0]  queue_count;
    logic        finish_err;
    logic        timeout;

    warp_dispatcher #(.QUEUE_DEPTH(4), .THREAD_COUNT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .submit_valid(submit_valid), .submit_kernel(submit_kernel),
        .submit_ready(submit_ready), .submit_reject(submit_reject),
        .kernel_out(kernel_out),
        .is_finished_in(is_finished_in), .finished_warp_id(finished_warp_id),
        .done_mask(done_mask), .done_clear(done_clear),
        .busy(busy), .queue_count(queue_count),
        .finish_err(finish_err), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        sv;
        logic [3:0]  sw;
        logic [2:0]  stc;
        logic [31:0] spc;
        logic        fin;
        logic [3:0]  fid;
        logic [14:0] clr;
        logic [3:0]  ew;
        logic [2:0]  etc_;
        logic [31:0] epc;
        logic        erdy, erej, ebusy, efe, eto;
        logic [2:0]  ecnt;
        logic [14:0] emask;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic add(input string n, input logic r, input logic sv, input int sw, input int stc,
                       input logic [31:0] spc, input logic fin, input int fid, input int clr,
                       input int ew, input int etc_, input logic [31:0] epc,
                       input logic rdy, input logic rej, input logic bsy, input logic fe,
                       input logic to, input int cnt, input int msk);
        vec_t v;
        v.name = n; v.rst = r; v.sv = sv; v.sw = 4'(sw); v.stc = 3'(stc); v.spc = spc;
        v.fin = fin; v.fid = 4'(fid); v.clr = 15'(clr);
        v.ew = 4'(ew); v.etc_ = 3'(etc_); v.epc = epc;
        v.erdy = rdy; v.erej = rej; v.ebusy = bsy; v.efe = fe; v.eto = to;
        v.ecnt = 3'(cnt); v.emask = 15'(msk);
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        rst                        = v.rst;
        submit_valid               = v.sv;
        submit_kernel.warp_id      = v.sw;
        submit_kernel.thread_count = v.stc;
        submit_kernel.start_pc     = v.spc;
        is_finished_in             = v.fin;
        finished_warp_id           = v.fid;
        done_clear                 = v.clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input vec_t v);
        n_cmp++;
        if (kernel_out.warp_id !== v.ew || kernel_out.thread_count !== v.etc_ ||
            kernel_out.start_pc !== v.epc || submit_ready !== v.erdy ||
            submit_reject !== v.erej || busy !== v.ebusy || finish_err !== v.efe ||
            timeout !== v.eto || queue_count !== v.ecnt || done_mask !== v.emask) begin
            n_fail++;
            $display("FAIL %s: got w=%h tc=%0d pc=%h rdy=%b rej=%b busy=%b ferr=%b to=%b cnt=%0d mask=%h; want w=%h tc=%0d pc=%h rdy=%b rej=%b busy=%b ferr=%b to=%b cnt=%0d mask=%h",
                     v.name, kernel_out.warp_id, kernel_out.thread_count, kernel_out.start_pc,
                     submit_ready, submit_reject, busy, finish_err, timeout, queue_count, done_mask,
                     v.ew, v.etc_, v.epc, v.erdy, v.erej, v.ebusy, v.efe, v.eto, v.ecnt, v.emask);
        end
    endtask

    task automatic run_rows(input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            apply(vecs[i]);
            check(vecs[i]);
        end
    endtask

    initial begin
        int   split;
        int   n;
        vec_t quiet;

        //   name            rst sv sw stc spc           fin fid clr     ew tc pc           rdy rej bsy fe to cnt mask
        add("reset",          1, 0, 0, 0, 32'h0,        0, 0, 0,       15,0,32'h0,        1,0,0,0,0, 0,'h00);
        add("sub_w1",         0, 1, 1, 4, 32'h12345678, 0, 0, 0,       15,0,32'h0,        1,0,1,0,0, 1,'h00);
        add("launch_w1",      0, 0, 0, 0, 32'h0,        0, 0, 0,        1,4,32'h12345678, 1,0,1,0,0, 0,'h00);
        add("fin_w1",         0, 0, 0, 0, 32'h0,        1, 1, 0,       15,0,32'h0,        1,0,1,0,0, 0,'h02);
        add("idle_after_w1",  0, 0, 0, 0, 32'h0,        0, 0, 0,       15,0,32'h0,        1,0,0,0,0, 0,'h02);
        add("sub_w2_clr1",    0, 1, 2, 1, 32'h200,      0, 0, 'h02,    15,0,32'h0,        1,0,1,0,0, 1,'h00);
        add("sub_w3",         0, 1, 3, 2, 32'h300,      0, 0, 0,        2,1,32'h200,      1,0,1,0,0, 1,'h00);
        add("sub_w4",         0, 1, 4, 3, 32'h400,      0, 0, 0,        2,1,32'h200,      1,0,1,0,0, 2,'h00);
        add("sub_w5",         0, 1, 5, 4, 32'h500,      0, 0, 0,        2,1,32'h200,      1,0,1,0,0, 3,'h00);
        add("sub_w6_full",    0, 1, 6, 4, 32'h600,      0, 0, 0,        2,1,32'h200,      0,0,1,0,0, 4,'h00);
        add("full_hold1",     0, 1, 7, 2, 32'h700,      0, 0, 0,        2,1,32'h200,      0,0,1,0,0, 4,'h00);
        add("full_hold2",     0, 1, 7, 2, 32'h700,      0, 0, 0,        2,1,32'h200,      0,0,1,0,0, 4,'h00);
        add("fin_w2",         0, 0, 0, 0, 32'h0,        1, 2, 0,       15,0,32'h0,        0,0,1,0,0, 4,'h04);
        add("launch_w3",      0, 0, 0, 0, 32'h0,        0, 0, 0,        3,2,32'h300,      1,0,1,0,0, 3,'h04);
        add("fin_w3",         0, 0, 0, 0, 32'h0,        1, 3, 0,       15,0,32'h0,        1,0,1,0,0, 3,'h0C);
        add("launch_w4",      0, 0, 0, 0, 32'h0,        0, 0, 0,        4,3,32'h400,      1,0,1,0,0, 2,'h0C);
        add("fin_w4",         0, 0, 0, 0, 32'h0,        1, 4, 0,       15,0,32'h0,        1,0,1,0,0, 2,'h1C);
        add("launch_w5",      0, 0, 0, 0, 32'h0,        0, 0, 0,        5,4,32'h500,      1,0,1,0,0, 1,'h1C);
        add("fin_w5",         0, 0, 0, 0, 32'h0,        1, 5, 0,       15,0,32'h0,        1,0,1,0,0, 1,'h3C);
        add("launch_w6",      0, 0, 0, 0, 32'h0,        0, 0, 0,        6,4,32'h600,      1,0,1,0,0, 0,'h3C);
        add("fin_w6",         0, 0, 0, 0, 32'h0,        1, 6, 0,       15,0,32'h0,        1,0,1,0,0, 0,'h7C);
        add("idle_drained",   0, 0, 0, 0, 32'h0,        0, 0, 0,       15,0,32'h0,        1,0,0,0,0, 0,'h7C);
        add("rej_w15",        0, 1,15, 1, 32'h0,        0, 0, 0,       15,0,32'h0,        1,1,0,0,0, 0,'h7C);
        add("rej_tc0",        0, 1, 2, 0, 32'h0,        0, 0, 0,       15,0,32'h0,        1,1,0,0,0, 0,'h7C);
        add("rej_tc5",        0, 1, 2, 5, 32'h0,        0, 0, 0,       15,0,32'h0,        1,1,0,0,0, 0,'h7C);
        add("rej_drop",       0, 0, 0, 0, 32'h0,        0, 0, 0,       15,0,32'h0,        1,0,0,0,0, 0,'h7C);
        add("sub_w3b_clr",    0, 1, 3, 2, 32'h300,      0, 0, 'h7C,    15,0,32'h0,        1,0,1,0,0, 1,'h00);
        add("launch_w3b",     0, 0, 0, 0, 32'h0,        0, 0, 0,        3,2,32'h300,      1,0,1,0,0, 0,'h00);
        add("bad_fin6",       0, 0, 0, 0, 32'h0,        1, 6, 0,        3,2,32'h300,      1,0,1,1,0, 0,'h00);
        add("hold_w3b",       0, 0, 0, 0, 32'h0,        0, 0, 0,        3,2,32'h300,      1,0,1,0,0, 0,'h00);
        add("fin_w3b",        0, 0, 0, 0, 32'h0,        1, 3, 0,       15,0,32'h0,        1,0,1,0,0, 0,'h08);
        add("fin_in_retire",  0, 0, 0, 0, 32'h0,        1, 3, 0,       15,0,32'h0,        1,0,0,1,0, 0,'h08);
        add("fin_in_idle",    0, 0, 0, 0, 32'h0,        1, 5, 0,       15,0,32'h0,        1,0,0,1,0, 0,'h08);
        add("quiet",          0, 0, 0, 0, 32'h0,        0, 0, 0,       15,0,32'h0,        1,0,0,0,0, 0,'h08);
        add("sub_w7",         0, 1, 7, 2, 32'h700,      0, 0, 0,       15,0,32'h0,        1,0,1,0,0, 1,'h08);
        add("launch_w7",      0, 0, 0, 0, 32'h0,        0, 0, 0,        7,2,32'h700,      1,0,1,0,0, 0,'h08);
        split = vecs.size();
        add("idle_after_to",  0, 0, 0, 0, 32'h0,        0, 0, 0,       15,0,32'h0,        1,0,0,0,0, 0,'h08);
        add("sub_w3c",        0, 1, 3, 1, 32'h3000,     0, 0, 0,       15,0,32'h0,        1,0,1,0,0, 1,'h08);
        add("relaunch_w3",    0, 0, 0, 0, 32'h0,        0, 0, 0,        3,1,32'h3000,     1,0,1,0,0, 0,'h08);
        add("fin_clr_race",   0, 0, 0, 0, 32'h0,        1, 3, 'h08,    15,0,32'h0,        1,0,1,0,0, 0,'h08);
        add("clr_w3",         0, 0, 0, 0, 32'h0,        0, 0, 'h08,    15,0,32'h0,        1,0,0,0,0, 0,'h00);
        add("sub_w4b",        0, 1, 4, 1, 32'h40,       0, 0, 0,       15,0,32'h0,        1,0,1,0,0, 1,'h00);
        add("launch_w4b",     0, 0, 0, 0, 32'h0,        0, 0, 0,        4,1,32'h40,       1,0,1,0,0, 0,'h00);
        add("rst_mid_run",    1, 0, 0, 0, 32'h0,        0, 0, 0,       15,0,32'h0,        1,0,0,0,0, 0,'h00);
        add("fin_after_rst",  0, 0, 0, 0, 32'h0,        1, 4, 0,       15,0,32'h0,        1,0,0,1,0, 0,'h00);

        run_rows(0, split);

        // Warp 7 never finishes: timeout must fire on the 8th edge after launch.
        quiet = vecs[split];
        n = 0;
        do begin
            apply(quiet);
            n++;
        end while (timeout !== 1'b1 && n < 20);
        n_cmp++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles, want 8", n);
        end
        n_cmp++;
        if (kernel_out.warp_id !== 4'hF || done_mask !== 15'h0008 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_retire: got w=%h mask=%h busy=%b, want w=f mask=0008 busy=1",
                     kernel_out.warp_id, done_mask, busy);
        end

        run_rows(split, vecs.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
